// File: rtl/voice_allocator_pkg.sv
// voice_allocator_pkg: shared defaults, FSM states and the latched note-event record
package voice_allocator_pkg;
  localparam int DEF_VOICES  = 8;
  localparam int DEF_V_WIDTH = 3;

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_e;

  typedef struct packed {
    logic       is_on;
    logic [6:0] key;
    logic [6:0] vel;
  } event_t;
endpackage

// File: rtl/voice_key_table.sv
// voice_key_table: per-voice key registers with one write port and an indexed match compare
module voice_key_table #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [V_WIDTH-1:0] wadr_i,
  input  logic [6:0]         wkey_i,
  input  logic [V_WIDTH-1:0] radr_i,
  input  logic [6:0]         key_i,
  output logic               match_o
);
  logic [6:0] tab_q [VOICES];

  // key held by each voice, rewritten when a note-on lands on that voice
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < VOICES; k++) tab_q[k] <= '0;
    end else if (we_i) begin
      tab_q[wadr_i] <= wkey_i;
    end
  end

  assign match_o = tab_q[radr_i] == key_i;
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: assigns note-on/off events to voice slots via a fixed-length scan
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int VOICES  = DEF_VOICES,
  parameter int V_WIDTH = DEF_V_WIDTH
) (
  input  logic               OSC_CLK,
  input  logic               reset_reg_N,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic               ev_is_on,
  input  logic [6:0]         ev_key,
  input  logic [6:0]         ev_vel,
  input  logic               all_notes_off,
  input  logic [VOICES-1:0]  voice_free,
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off
);
  state_e             state_q, state_d;
  event_t             ev_q, ev_d;
  logic [V_WIDTH-1:0] idx_q, idx_d, hit_adr_q, hit_adr_d, free_adr_q, free_adr_d;
  logic [V_WIDTH-1:0] steal_q, steal_d, adr_q, adr_d;
  logic               hit_q, hit_d, free_q, free_d, note_q, note_d;
  logic [VOICES-1:0]  keys_q, keys_d;
  logic [7:0]         key_val_q, key_val_d, vel_on_q, vel_on_d, vel_off_q, vel_off_d;
  logic               tab_match, tab_we, last, cur_hit, cur_free, fin_hit, fin_free;
  logic [V_WIDTH-1:0] fin_hit_adr, fin_free_adr, v;

  voice_key_table #(.VOICES(VOICES), .V_WIDTH(V_WIDTH)) u_tab (
    .clk     (OSC_CLK),
    .rst_n   (reset_reg_N),
    .we_i    (tab_we),
    .wadr_i  (v),
    .wkey_i  (ev_q.key),
    .radr_i  (idx_q),
    .key_i   (ev_q.key),
    .match_o (tab_match)
  );

  // state and output registers; the commit result is loaded as COMMIT is entered
  always_ff @(posedge OSC_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q    <= IDLE;
      ev_q       <= '0;
      idx_q      <= '0;
      hit_q      <= 1'b0;
      hit_adr_q  <= '0;
      free_q     <= 1'b0;
      free_adr_q <= '0;
      steal_q    <= '0;
      adr_q      <= '0;
      note_q     <= 1'b0;
      keys_q     <= '0;
      key_val_q  <= '0;
      vel_on_q   <= '0;
      vel_off_q  <= '0;
    end else begin
      state_q    <= state_d;
      ev_q       <= ev_d;
      idx_q      <= idx_d;
      hit_q      <= hit_d;
      hit_adr_q  <= hit_adr_d;
      free_q     <= free_d;
      free_adr_q <= free_adr_d;
      steal_q    <= steal_d;
      adr_q      <= adr_d;
      note_q     <= note_d;
      keys_q     <= keys_d;
      key_val_q  <= key_val_d;
      vel_on_q   <= vel_on_d;
      vel_off_q  <= vel_off_d;
    end
  end

  assign cur_hit      = keys_q[idx_q] && tab_match;
  assign cur_free     = voice_free[idx_q] && !keys_q[idx_q];
  assign fin_hit      = hit_q || cur_hit;
  assign fin_free     = free_q || cur_free;
  assign fin_hit_adr  = hit_q ? hit_adr_q : idx_q;
  assign fin_free_adr = free_q ? free_adr_q : idx_q;
  assign v            = fin_hit ? fin_hit_adr : fin_free ? fin_free_adr : steal_q;
  assign last         = idx_q == V_WIDTH'(VOICES - 1);

  // next-state: accept in IDLE, first-hit tracking in SCAN, decision on the last scan cycle
  always_comb begin
    state_d    = state_q;
    ev_d       = ev_q;
    idx_d      = idx_q;
    hit_d      = hit_q;
    hit_adr_d  = hit_adr_q;
    free_d     = free_q;
    free_adr_d = free_adr_q;
    steal_d    = steal_q;
    adr_d      = adr_q;
    note_d     = 1'b0;
    keys_d     = keys_q;
    key_val_d  = key_val_q;
    vel_on_d   = vel_on_q;
    vel_off_d  = vel_off_q;
    tab_we     = 1'b0;
    if (all_notes_off) begin
      keys_d  = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (ev_valid) begin
          ev_d    = '{is_on: ev_is_on && (ev_vel != 7'd0), key: ev_key, vel: ev_vel};
          idx_d   = '0;
          hit_d   = 1'b0;
          free_d  = 1'b0;
          state_d = SCAN;
        end
        SCAN: begin
          hit_d      = fin_hit;
          hit_adr_d  = fin_hit_adr;
          free_d     = fin_free;
          free_adr_d = fin_free_adr;
          idx_d      = idx_q + 1'b1;
          if (last) begin
            state_d = COMMIT;
            if (ev_q.is_on) begin
              tab_we    = 1'b1;
              keys_d[v] = 1'b1;
              adr_d     = v;
              key_val_d = {1'b0, ev_q.key};
              vel_on_d  = {1'b0, ev_q.vel};
              note_d    = 1'b1;
              if (!fin_hit && !fin_free)
                steal_d = steal_q == V_WIDTH'(VOICES - 1) ? '0 : steal_q + 1'b1;
            end else if (fin_hit) begin
              keys_d[v] = 1'b0;
              adr_d     = v;
              key_val_d = {1'b0, ev_q.key};
              vel_off_d = {1'b0, ev_q.vel};
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign ev_ready    = state_q == IDLE;
  assign keys_on     = keys_q;
  assign note_on     = note_q;
  assign cur_key_adr = adr_q;
  assign cur_key_val = key_val_q;
  assign cur_vel_on  = vel_on_q;
  assign cur_vel_off = vel_off_q;
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed-vector self-checking bench for voice_allocator
module tb_voice_allocator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ev_valid = 1'b0, ev_is_on = 1'b0, all_off = 1'b0;
  logic [6:0] ev_key = '0, ev_vel = '0;
  logic [7:0] vfree = 8'hFF;
  logic       ev_ready, note_on;
  logic [7:0] keys_on, cur_key_val, cur_vel_on, cur_vel_off;
  logic [2:0] cur_key_adr;
  int         n_chk = 0, n_pass = 0, pulses;
  logic [8:0] mask;

  voice_allocator dut (
    .OSC_CLK       (clk),
    .reset_reg_N   (rst_n),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_is_on      (ev_is_on),
    .ev_key        (ev_key),
    .ev_vel        (ev_vel),
    .all_notes_off (all_off),
    .voice_free    (vfree),
    .keys_on       (keys_on),
    .note_on       (note_on),
    .cur_key_adr   (cur_key_adr),
    .cur_key_val   (cur_key_val),
    .cur_vel_on    (cur_vel_on),
    .cur_vel_off   (cur_vel_off)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // drive one event from an IDLE negedge and stop at the COMMIT-cycle negedge
  task automatic ev(input logic on, input logic [6:0] k, input logic [6:0] v);
    ev_valid = 1'b1; ev_is_on = on; ev_key = k; ev_vel = v;
    check("ready_idle", ev_ready, 1);
    @(negedge clk);
    ev_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      pulses += int'(note_on);
      @(negedge clk);
    end
    check("scan_quiet", pulses, 0);
    check("busy_commit", ev_ready, 0);
  endtask

  task automatic post();
    @(negedge clk);
    check("ready_back", ev_ready, 1);
    check("note_after", note_on, 0);
  endtask

  task automatic exp_out(input logic [7:0] k, input logic n, input logic [2:0] a,
                         input logic [7:0] kv, input logic [7:0] von, input logic [7:0] voff);
    check("keys_on", keys_on, k);
    check("note_on", note_on, n);
    check("key_adr", cur_key_adr, a);
    check("key_val", cur_key_val, kv);
    check("vel_on", cur_vel_on, von);
    check("vel_off", cur_vel_off, voff);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready", ev_ready, 1);
    exp_out(8'h00, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    ev(1, 60, 100); exp_out(8'h01, 1, 0, 60, 100, 0); post();
    ev(1, 64, 90);  exp_out(8'h03, 1, 1, 64, 90, 0);  post();
    ev(1, 60, 20);  exp_out(8'h03, 1, 0, 60, 20, 0);  post();
    ev(0, 60, 40);  exp_out(8'h02, 0, 0, 60, 20, 40); post();
    ev(1, 64, 0);   exp_out(8'h00, 0, 1, 64, 20, 0);  post();
    ev(0, 99, 5);   exp_out(8'h00, 0, 1, 64, 20, 0);  post();
    for (int k = 0; k < 8; k++) begin
      mask = (9'h1 << (k + 1)) - 9'h1;
      ev(1, 7'(60 + k), 50);
      exp_out(mask[7:0], 1, 3'(k), 8'(60 + k), 50, 0);
      post();
    end
    vfree = 8'h00;
    for (int s = 0; s < 9; s++) begin
      ev(1, 7'(70 + s), 60);
      exp_out(8'hFF, 1, 3'(s % 8), 8'(70 + s), 60, 0);
      post();
    end
    ev_valid = 1'b1; ev_is_on = 1'b1; ev_key = 80; ev_vel = 70;
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (2) @(negedge clk);
    all_off = 1'b1;
    @(negedge clk);
    all_off = 1'b0;
    check("ano_ready", ev_ready, 1);
    exp_out(8'h00, 0, 0, 78, 60, 0);
    pulses = 0;
    repeat (10) begin
      pulses += int'(note_on);
      @(negedge clk);
    end
    check("ano_quiet", pulses, 0);
    ev(1, 81, 30); exp_out(8'h02, 1, 1, 81, 30, 0); post();
    ev_valid = 1'b1; all_off = 1'b1; ev_key = 90;
    @(negedge clk);
    ev_valid = 1'b0; all_off = 1'b0;
    check("coinc_ready", ev_ready, 1);
    check("coinc_keys", keys_on, 8'h00);
    @(negedge clk);
    check("coinc_idle", ev_ready, 1);
    vfree = 8'hFF;
    ev(1, 85, 10); exp_out(8'h01, 1, 0, 85, 10, 0); post();
    ev_valid = 1'b1; ev_key = 86; ev_vel = 11;
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("arst_ready", ev_ready, 1);
    exp_out(8'h00, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle", ev_ready, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
